// File: rtl/spi_sram_responder_pkg.sv
// Shared definitions for the SPI serial-SRAM responder: opcode constants,
// FSM state encoding and the default status byte returned by RDSR.
package spi_sram_responder_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  localparam logic [7:0] STATUS_VALUE_DEF = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_STATUS,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_sram_responder_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a third flop so the
// synchronized level can be edge-detected.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   async_in   - asynchronous input
//   level      - synchronized copy of async_in
//   rise, fall - one-clk pulses on synchronized rising / falling edge
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  // Edge pulses are combinational off the sync stage so they line up with
  // other signals passed through a plain two-flop synchronizer.
  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave that behaves like a byte-addressed serial SRAM.
// Decodes READ / WRITE / RDSR, backs the data with an internal byte array
// and shifts read data out on miso, MSB first.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   sck, cs, mosi      - SPI bus from the master (asynchronous to clk)
//   miso               - SPI data back to the master
//   wr_strobe          - one-clk pulse per byte committed to storage
//   wr_addr, wr_data   - address and data of the committed byte
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | cs high, waiting for cs falling edge
// ST_CMD     | receiving the command byte
// ST_ADDR    | receiving the 16-bit address (two bytes)
// ST_RDATA   | shifting stored bytes out, address auto-increments
// ST_WDATA   | receiving bytes and committing them to storage
// ST_STATUS  | shifting the status byte out repeatedly
// ST_DISCARD | unknown command, ignore everything until cs high
module spi_sram_responder
  import spi_sram_responder_pkg::*;
#(
  parameter int         DEPTH_LOG2   = 9,
  parameter logic [7:0] STATUS_VALUE = STATUS_VALUE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  wr_strobe,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sck),
    .level    (sck_lvl),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (cs),
    .level    (cs_lvl),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  logic unused_sync;
  assign unused_sync = sck_lvl ^ cs_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  logic [7:0] mem [2**DEPTH_LOG2];

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [2:0]            tx_cnt;
  logic [7:0]            rx_sr;
  logic [7:0]            tx_sr;
  logic [DEPTH_LOG2-1:0] addr;
  logic                  addr_hi_done;
  logic                  is_write;

  logic [7:0]            rx_next;
  logic [DEPTH_LOG2-1:0] addr_shift;
  logic                  byte_done;

  assign rx_next    = {rx_sr[6:0], mosi_s};
  // Shifting the address through a DEPTH_LOG2-wide register keeps only the
  // low bits; the unused upper address bits fall off the top.
  assign addr_shift = {addr[DEPTH_LOG2-2:0], mosi_s};
  assign byte_done  = sck_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      tx_cnt       <= 3'd0;
      rx_sr        <= 8'h00;
      tx_sr        <= 8'h00;
      addr         <= '0;
      addr_hi_done <= 1'b0;
      is_write     <= 1'b0;
      miso         <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (state != ST_IDLE && cs_lvl) begin
        // Any partially received byte is simply dropped here.
        state   <= ST_IDLE;
        miso    <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        if (sck_rise && state != ST_IDLE) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= 3'd0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              addr_hi_done <= 1'b0;
              case (rx_next)
                CMD_READ: begin
                  state    <= ST_ADDR;
                  is_write <= 1'b0;
                end
                CMD_WRITE: begin
                  state    <= ST_ADDR;
                  is_write <= 1'b1;
                end
                CMD_RDSR: begin
                  state  <= ST_STATUS;
                  tx_sr  <= STATUS_VALUE;
                  tx_cnt <= 3'd0;
                end
                default: state <= ST_DISCARD;
              endcase
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              addr <= addr_shift;
              if (bit_cnt == 3'd7) begin
                if (!addr_hi_done) begin
                  addr_hi_done <= 1'b1;
                end else if (is_write) begin
                  state <= ST_WDATA;
                end else begin
                  // Prefetch the first byte so bit 7 is ready on the next fall.
                  state  <= ST_RDATA;
                  tx_sr  <= mem[addr_shift];
                  addr   <= addr_shift + 1'b1;
                  tx_cnt <= 3'd0;
                end
              end
            end
          end
          ST_RDATA, ST_STATUS: begin
            if (sck_fall) begin
              miso   <= tx_sr[7];
              tx_cnt <= tx_cnt + 3'd1;
              if (tx_cnt == 3'd7) begin
                if (state == ST_RDATA) begin
                  tx_sr <= mem[addr];
                  addr  <= addr + 1'b1;
                end else begin
                  tx_sr <= STATUS_VALUE;
                end
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end
          end
          ST_WDATA: begin
            if (byte_done) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= rx_next;
              addr      <= addr + 1'b1;
            end
          end
          ST_DISCARD: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Storage is committed one clock after the strobe; reads only happen in a
  // later transaction, so the extra cycle is never visible.
  always_ff @(posedge clk) begin
    if (wr_strobe) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: drives SPI transactions with a
// mode-0 master model and checks miso bytes and committed writes.
module tb_spi_sram_responder;

  localparam int H = 5;  // sck half period in clk cycles

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       wr_strobe;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] wr_log[$];

  always #5 clk = ~clk;

  spi_sram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always @(negedge clk) begin
    if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 17'h1ffff;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      tick(H);
      sck = 1'b1;
      rx  = {rx[6:0], miso};
      tick(H);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    tick(H);
    cs = 1'b1;
    tick(6);
  endtask

  task automatic write_txn(input logic [15:0] a, input bq_t d);
    logic [7:0] r;
    cs_begin();
    spi_byte(8'h02, r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
    foreach (d[i]) spi_byte(d[i], r);
    cs_end();
  endtask

  task automatic read_txn(input logic [15:0] a, input int n, output bq_t got);
    logic [7:0] r;
    got = {};
    cs_begin();
    spi_byte(8'h03, r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      got.push_back(r);
    end
    cs_end();
  endtask

  initial begin
    bq_t        wd;
    bq_t        rd;
    logic [7:0] r;

    tick(3);
    check("rst miso", miso, 1'b0);
    check("rst wr_strobe", wr_strobe, 1'b0);
    check("rst wr_addr", wr_addr, 9'h000);
    check("rst wr_data", wr_data, 8'h00);
    reset = 1'b0;
    tick(4);

    // Basic write then read back
    wr_log.delete();
    wd = '{8'hAB, 8'hCD};
    write_txn(16'h0010, wd);
    check("t1 nwr", wr_log.size(), 2);
    check("t1 wr0", log_at(0), {9'h010, 8'hAB});
    check("t1 wr1", log_at(1), {9'h011, 8'hCD});
    read_txn(16'h0010, 2, rd);
    check("t1 rd0", rd[0], 8'hAB);
    check("t1 rd1", rd[1], 8'hCD);

    // Address wrap at top of storage
    wr_log.delete();
    wd = '{8'h11, 8'h22};
    write_txn(16'h01FF, wd);
    check("t2 nwr", wr_log.size(), 2);
    check("t2 wr0", log_at(0), {9'h1FF, 8'h11});
    check("t2 wr1", log_at(1), {9'h000, 8'h22});
    read_txn(16'h01FF, 2, rd);
    check("t2 rd0", rd[0], 8'h11);
    check("t2 rd1", rd[1], 8'h22);

    // RDSR
    wr_log.delete();
    cs_begin();
    spi_byte(8'h05, r);
    spi_byte(8'h00, r);
    check("t3 sr0", r, 8'h40);
    spi_byte(8'h00, r);
    check("t3 sr1", r, 8'h40);
    cs_end();
    check("t3 nwr", wr_log.size(), 0);

    // Unknown command is discarded
    cs_begin();
    spi_byte(8'h9F, r);
    check("t4 cmd miso", r, 8'h00);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, r);
      check("t4 discard miso", r, 8'h00);
    end
    cs_end();
    check("t4 nwr", wr_log.size(), 0);
    read_txn(16'h0010, 2, rd);
    check("t4 rd0", rd[0], 8'hAB);
    check("t4 rd1", rd[1], 8'hCD);

    // Partial write byte is dropped
    wd = '{8'h5A};
    write_txn(16'h0020, wd);
    wr_log.delete();
    cs_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h00, r);
    spi_byte(8'h20, r);
    spi_bits(8'hFF, 5, r);
    cs_end();
    check("t5 nwr", wr_log.size(), 0);
    read_txn(16'h0020, 1, rd);
    check("t5 rd0", rd[0], 8'h5A);

    // Reset in the middle of a read burst
    cs_begin();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h10, r);
    spi_byte(8'h00, r);
    check("t6 rd0", r, 8'hAB);
    tick(4);
    check("t6 pre-reset miso", miso, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t6 reset miso", miso, 1'b0);
    reset = 1'b0;
    cs = 1'b1;
    tick(8);
    check("t6 idle miso", miso, 1'b0);
    read_txn(16'h0010, 2, rd);
    check("t6 rd after reset 0", rd[0], 8'hAB);
    check("t6 rd after reset 1", rd[1], 8'hCD);
    check("t6 nwr", wr_log.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
